// File: rtl/spike_packet_router.sv
// rtl/spike_packet_router.sv - FIFO-buffered spike packet router to four neuron-core ports
//
// Purpose:
//   Accepts merged spike packets, buffers them in a DEPTH-entry FIFO and
//   presents the head packet to one of four ports selected by its top two
//   bits. Delivery is strictly in order; a stalled port blocks later packets.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_data     in   [WIDTH-1:0] packet: dest in [WIDTH-1:WIDTH-2], payload below
//   in_valid    in   in_data is valid
//   in_ready    out  router can accept a packet this cycle
//   out_data    out  [WIDTH-3:0] payload of head packet, broadcast to all ports
//   out_valid   out  [3:0] one-hot port select for head packet, zero when empty
//   out_ready   in   [3:0] per-port consumer ready
//   fifo_count  out  [CW-1:0] current occupancy
//   pkt_cnt     out  [63:0] per-port saturating delivery counters (16 bits each)
//
// Optional feature macro: ROUTER_PKT_CNT_EN (adds pkt_cnt and its counters).

module spike_packet_router #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-3:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CW-1:0]    fifo_count
`ifdef ROUTER_PKT_CNT_EN
    ,
    output logic [63:0]      pkt_cnt
`endif
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] head;
    logic [1:0]       head_dest;
    logic             not_empty;
    logic             push;
    logic             pop;

    assign head      = mem_q[rd_ptr_q];
    assign head_dest = head[WIDTH-1 -: 2];

    // Gating with reset keeps outputs quiet during the reset cycle itself,
    // before the registered state has been cleared.
    assign not_empty = (count_q != '0) && !reset;

    assign out_valid  = not_empty ? (4'b0001 << head_dest) : 4'b0000;
    assign out_data   = not_empty ? head[WIDTH-3:0] : '0;
    assign fifo_count = reset ? '0 : count_q;

    // No pass-through when full: a same-cycle pop does not open in_ready.
    assign in_ready = (count_q != FULL) && !reset;

    assign push = in_valid && in_ready;
    // Only the selected port's ready matters since out_valid is one-hot.
    assign pop  = |(out_valid & out_ready);

    // DEPTH is a power of two, so pointer increment wraps naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible when count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef ROUTER_PKT_CNT_EN
    logic [15:0] cnt_q [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int d = 0; d < 4; d++) begin
                cnt_q[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (pop && (head_dest == 2'(d)) && (cnt_q[d] != 16'hFFFF)) begin
                    cnt_q[d] <= cnt_q[d] + 16'd1;
                end
            end
        end
    end

    assign pkt_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= FULL)
                else $error("router occupancy above DEPTH");
            assert (!(pop && (count_q == '0)))
                else $error("router pop from empty FIFO");
            assert ($onehot0(out_valid))
                else $error("router out_valid not one-hot");
        end
    end
`endif

endmodule
